mux2_sel: RTL and testbench

// - Two-input selector: routes IN0 or IN1 to the output under control of SEL.
// - Leaf datapath primitive used wherever a 1-of-2 choice is needed.
// - Provides a zero-latency combinational output and a one-cycle registered copy for timing-critical consumers.
//

---
 rtl/mux_pkg.sv | 9 +
 rtl/mux2_cell.sv | 19 +
 rtl/mux2_sel.sv | 50 +++++
 tb/tb_mux2_sel.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared encodings for the 2:1 selector family.
// Select values and the default data width used by mux2_cell and mux2_sel.
package mux_pkg;

    localparam logic MUX_SEL_IN0   = 1'b0;
    localparam logic MUX_SEL_IN1   = 1'b1;
    localparam int   DEFAULT_WIDTH = 1;

endpackage : mux_pkg

// File: rtl/mux2_cell.sv
// Combinational WIDTH-bit 2:1 selector.
// Built on the conditional operator so an unknown select merges the inputs bitwise in simulation.
module mux2_cell
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // A ternary is used rather than an if/else.
    // With an X select, bits where in0 and in1 agree keep their value.
    // Every other bit goes to X instead of silently taking one of the inputs.
    assign y = (sel == MUX_SEL_IN1) ? in1 : in0;

endmodule : mux2_cell

// File: rtl/mux2_sel.sv
// Two-input selector with a zero-latency output (MUX_OUT).
// A one-cycle registered copy (MUX_OUT_Q) has a synchronous active-high reset.
module mux2_sel
    import mux_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic             SEL,
    output logic [WIDTH-1:0] MUX_OUT,
    output logic [WIDTH-1:0] MUX_OUT_Q
);

    mux2_cell #(
        .WIDTH (WIDTH)
    ) u_cell (
        .in0 (IN0),
        .in1 (IN1),
        .sel (SEL),
        .y   (MUX_OUT)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            MUX_OUT_Q <= RST_VAL;
        end else begin
            MUX_OUT_Q <= MUX_OUT;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only marker so the registered-path check skips the very first edge.
    logic seen_edge;

    always_ff @(posedge CLK) begin
        seen_edge <= 1'b1;
    end

    a_comb_sel: assert property (@(posedge CLK)
        !$isunknown(SEL) |-> (MUX_OUT === ((SEL == MUX_SEL_IN1) ? IN1 : IN0)));

    a_reg_follow: assert property (@(posedge CLK)
        (seen_edge === 1'b1 && $past(RST) === 1'b0) |-> (MUX_OUT_Q === $past(MUX_OUT)));
`endif

endmodule : mux2_sel

// File: tb/tb_mux2_sel.sv
// Directed bench for mux2_sel at WIDTH=1 and at WIDTH=8 with RST_VAL=8'hA5.
// A per-cycle model compare runs alongside hand-computed literal checks.
module tb_mux2_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0, in1, sel;
    logic       out1, out1_q;
    logic [7:0] a8, b8;
    logic       sel8;
    logic [7:0] out8, out8_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_sel #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .CLK(clk), .RST(rst), .IN0(in0), .IN1(in1), .SEL(sel),
        .MUX_OUT(out1), .MUX_OUT_Q(out1_q)
    );

    mux2_sel #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .CLK(clk), .RST(rst), .IN0(a8), .IN1(b8), .SEL(sel8),
        .MUX_OUT(out8), .MUX_OUT_Q(out8_q)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Selection rule: a known select picks one input; an unknown select keeps agreeing bits and X elsewhere.
    function automatic logic [7:0] pick(input logic [7:0] i0, input logic [7:0] i1, input logic s, input int w);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < w; b++) begin
            if (s === 1'b1)      r[b] = i1[b];
            else if (s === 1'b0) r[b] = i0[b];
            else                 r[b] = (i0[b] === i1[b]) ? i0[b] : 1'bx;
        end
        return r;
    endfunction

    // Model of the registered outputs, updated from the inputs present at each rising edge.
    logic [7:0] m_q1, m_q8;
    bit         q_known = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_q1 = 8'h00;
            m_q8 = 8'hA5;
            q_known = 1'b1;
        end else begin
            m_q1 = pick({7'b0, in0}, {7'b0, in1}, sel, 1);
            m_q8 = pick(a8, b8, sel8, 8);
        end
        #1;
        chk("cyc_out1", {7'b0, out1}, pick({7'b0, in0}, {7'b0, in1}, sel, 1));
        chk("cyc_out8", out8, pick(a8, b8, sel8, 8));
        if (q_known) begin
            chk("cyc_q1", {7'b0, out1_q}, m_q1);
            chk("cyc_q8", out8_q, m_q8);
        end
    end

    task automatic drive(input logic i0, input logic i1, input logic s);
        @(negedge clk);
        in0 = i0; in1 = i1; sel = s;
        #1;
    endtask

    logic [7:0] truth;
    logic       probe;
    bit         four_state;

    initial begin
        truth = 8'b1101_1000;  // indexed by {in0, in1, sel}
        probe = 1'bx;
        four_state = $isunknown(probe);

        // Reset held for two edges with SEL=1, IN1=1
        rst = 1'b1; in0 = 1'b0; in1 = 1'b1; sel = 1'b1;
        a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0;
        #1;
        chk("out_in_reset", {7'b0, out1}, 8'h01);
        @(negedge clk);
        @(negedge clk);
        chk("q_reset_w1", {7'b0, out1_q}, 8'h00);
        chk("q_reset_w8", out8_q, 8'hA5);
        chk("out_still_in_reset", {7'b0, out1}, 8'h01);
        rst = 1'b0;
        @(negedge clk);
        chk("q_after_release", {7'b0, out1_q}, 8'h01);

        // SEL=0: follow IN0, ignore IN1
        drive(0, 0, 0); chk("w0_a", {7'b0, out1}, 8'h00);
        drive(1, 0, 0); chk("w0_b", {7'b0, out1}, 8'h01);
        drive(1, 1, 0); chk("w0_c", {7'b0, out1}, 8'h01);
        drive(0, 1, 0); chk("w0_d", {7'b0, out1}, 8'h00);
        // SEL=1: IN0 toggling has no effect
        drive(0, 1, 1); chk("w1_a", {7'b0, out1}, 8'h01);
        drive(1, 1, 1); chk("w1_b", {7'b0, out1}, 8'h01);
        drive(0, 1, 1); chk("w1_c", {7'b0, out1}, 8'h01);
        drive(0, 0, 1); chk("w1_d", {7'b0, out1}, 8'h00);

        // SEL toggled within half a cycle: output follows immediately
        drive(1, 0, 0);
        chk("tog_s0", {7'b0, out1}, 8'h01);
        sel = 1'b1; #1; chk("tog_s1", {7'b0, out1}, 8'h00);
        sel = 1'b0; #1; chk("tog_s0b", {7'b0, out1}, 8'h01);

        // Exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(v[2], v[1], v[0]);
            chk($sformatf("tt_%0d", i), {7'b0, out1}, {7'b0, truth[i]});
        end

        // Reset asserted for a single edge while MUX_OUT=1
        drive(1, 0, 0);
        @(negedge clk);
        chk("mid_pre_q", {7'b0, out1_q}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_q_reset", {7'b0, out1_q}, 8'h00);
        chk("mid_out_held", {7'b0, out1}, 8'h01);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_q_back", {7'b0, out1_q}, 8'h01);
        chk("mid_out_after", {7'b0, out1}, 8'h01);

        // 8-bit instance
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'hC3; sel8 = 1'b0; #1;
        chk("w8_sel0", out8, 8'h3C);
        @(negedge clk);
        chk("w8_q_sel0", out8_q, 8'h3C);
        sel8 = 1'b1; #1;
        chk("w8_sel1", out8, 8'hC3);
        @(negedge clk);
        chk("w8_q_sel1", out8_q, 8'hC3);
        rst = 1'b1;
        @(negedge clk);
        chk("w8_q_reset", out8_q, 8'hA5);
        chk("w8_out_in_reset", out8, 8'hC3);
        rst = 1'b0;
        @(negedge clk);
        chk("w8_q_release", out8_q, 8'hC3);

        // Unknown select: agreeing bits survive, differing bits go X
        @(negedge clk);
        in0 = 1'b1; in1 = 1'b1; sel = 1'bx; #1;
        chk("x_sel_agree", {7'b0, out1}, 8'h01);
        if (four_state) begin
            @(negedge clk);
            in0 = 1'b0; #1;
            chk("x_sel_differ", {7'b0, out1}, {7'b0, 1'bx});
        end
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux2_sel
